stream_fifo_eof: RTL and testbench

//  Parametrised single-clock stream FIFO between a Xillybus user stream and a compute core (e.g. Stencil).

---
 rtl/stream_fifo_eof_pkg.sv | 14 +
 rtl/stream_fifo_eof_sdp_ram.sv | 37 +++
 rtl/stream_fifo_eof.sv | 157 +++++++++++++++
 tb/tb_stream_fifo_eof.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_eof_pkg.sv
// Shared constants for the stream FIFO family: output-mode selectors and
// the width helpers used to size level and frame counters.
package stream_fifo_eof_pkg;

    localparam int FWFT_STANDARD = 0;
    localparam int FWFT_FALLTHRU = 1;
    localparam int FRAME_CNT_W   = 32;

    // Level must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int level_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/stream_fifo_eof_sdp_ram.sv
// Simple dual-port RAM, WIDTH x 2**DEPTH_LOG2, synchronous read with an
// output register that holds its value when re is low.
module stream_fifo_eof_sdp_ram #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register reset maps onto the block RAM's output set/reset pin.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/stream_fifo_eof.sv
// Single-clock stream FIFO with level, almost flags, sticky error flags and
// frame-length EOF generation for a host-facing user stream.
module stream_fifo_eof
    import stream_fifo_eof_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9,
    parameter int AF_THRESH  = 480,
    parameter int AE_THRESH  = 16,
    parameter int FWFT       = 0
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   almost_empty,
    output logic [DEPTH_LOG2:0]    level,
    input  logic [31:0]            frame_len,
    output logic                   eof,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int LW = level_width(DEPTH_LOG2);
    localparam logic [LW-1:0] DEPTH_L = LW'(1 << DEPTH_LOG2);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    logic [DEPTH_LOG2-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]          level_reg, level_next;
    logic                   full_reg, af_reg, empty_reg, ae_reg;
    logic                   ovf_reg, unf_reg, eof_reg, eof_next;
    logic [FRAME_CNT_W-1:0] wr_cnt_reg, rd_cnt_reg, rd_cnt_next;
    logic [FRAME_CNT_W-1:0] frame_len_reg, frame_len_eff;
    logic                   frame_lock_reg, frame_wr_done;
    logic                   wr_accept, rd_accept, ram_rd, empty_next;
    logic [WIDTH-1:0]       ram_q;

    stream_fifo_eof_sdp_ram #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .srst  (srst),
        .we    (wr_accept),
        .waddr (wr_ptr_reg),
        .wdata (din),
        .re    (ram_rd),
        .raddr (rd_ptr_reg),
        .rdata (ram_q)
    );

    // Until the first write locks it, the live frame_len governs the frame.
    always_comb begin
        frame_len_eff = frame_lock_reg ? frame_len_reg : frame_len;
        frame_wr_done = (frame_len_eff != '0) && (wr_cnt_reg == frame_len_eff);
        wr_accept     = wr_en && !full_reg && !frame_wr_done;
        rd_accept     = rd_en && !empty_reg;
        level_next    = level_reg;
        case ({wr_accept, rd_accept})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
        rd_cnt_next = rd_cnt_reg + FRAME_CNT_W'(rd_accept);
        eof_next    = eof_reg || ((frame_len_eff != '0) &&
                                  (rd_cnt_next == frame_len_eff) && empty_next);
    end

    generate
        if (FWFT == FWFT_FALLTHRU) begin : g_fwft
            // Two-stage output: RAM output register, then the presented word.
            logic [LW-1:0]    ram_cnt_reg;
            logic             ram_valid_reg;
            logic [WIDTH-1:0] dout_reg;
            logic             load_out;

            assign load_out   = ram_valid_reg && (empty_reg || rd_accept);
            assign ram_rd     = (ram_cnt_reg != '0) && (!ram_valid_reg || load_out);
            assign empty_next = !(load_out || (!empty_reg && !rd_accept));
            assign dout       = dout_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    ram_cnt_reg   <= '0;
                    ram_valid_reg <= 1'b0;
                    dout_reg      <= '0;
                end else begin
                    ram_cnt_reg   <= ram_cnt_reg + LW'(wr_accept) - LW'(ram_rd);
                    ram_valid_reg <= ram_rd || (ram_valid_reg && !load_out);
                    if (load_out) begin
                        dout_reg <= ram_q;
                    end
                end
            end
        end else begin : g_std
            assign ram_rd     = rd_accept;
            assign empty_next = (level_next == '0);
            assign dout       = ram_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            full_reg       <= 1'b0;
            af_reg         <= 1'b0;
            empty_reg      <= 1'b1;
            ae_reg         <= 1'b1;
            ovf_reg        <= 1'b0;
            unf_reg        <= 1'b0;
            eof_reg        <= 1'b0;
            wr_cnt_reg     <= '0;
            rd_cnt_reg     <= '0;
            frame_len_reg  <= '0;
            frame_lock_reg <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
            if (ram_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (wr_accept && !frame_lock_reg) begin
                frame_lock_reg <= 1'b1;
                frame_len_reg  <= frame_len;
            end
            level_reg  <= level_next;
            full_reg   <= (level_next == DEPTH_L);
            af_reg     <= (level_next >= AF_L);
            ae_reg     <= (level_next <= AE_L);
            empty_reg  <= empty_next;
            ovf_reg    <= ovf_reg || (wr_en && !wr_accept);
            unf_reg    <= unf_reg || (rd_en && empty_reg);
            rd_cnt_reg <= rd_cnt_next;
            eof_reg    <= eof_next;
        end
    end

    assign full         = full_reg;
    assign almost_full  = af_reg;
    assign empty        = empty_reg;
    assign almost_empty = ae_reg;
    assign level        = level_reg;
    assign eof          = eof_reg;
    assign overflow     = ovf_reg;
    assign underflow    = unf_reg;

endmodule

// File: tb/tb_stream_fifo_eof.sv
// Bench for stream_fifo_eof: queue model checked every cycle on the standard
// instance, plus directed checks on a first-word-fall-through instance.
module tb_stream_fifo_eof;

    localparam int W     = 32;
    localparam int DL2   = 9;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srst, wr_en, rd_en;
    logic [W-1:0]  din, dout;
    logic [31:0]   frame_len;
    logic          full, af, empty, ae, eof, ovf, unf;
    logic [DL2:0]  level;

    logic          srst1, wr1, rd1;
    logic [W-1:0]  din1, dout1;
    logic [31:0]   frame_len1;
    logic          full1, af1, empty1, ae1, eof1, ovf1, unf1;
    logic [DL2:0]  level1;

    stream_fifo_eof #(.WIDTH(W), .DEPTH_LOG2(DL2), .AF_THRESH(480),
                      .AE_THRESH(16), .FWFT(0)) dut0 (
        .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .full(full),
        .almost_full(af), .rd_en(rd_en), .dout(dout), .empty(empty),
        .almost_empty(ae), .level(level), .frame_len(frame_len), .eof(eof),
        .overflow(ovf), .underflow(unf));

    stream_fifo_eof #(.WIDTH(W), .DEPTH_LOG2(DL2), .AF_THRESH(480),
                      .AE_THRESH(16), .FWFT(1)) dut1 (
        .clk(clk), .srst(srst1), .din(din1), .wr_en(wr1), .full(full1),
        .almost_full(af1), .rd_en(rd1), .dout(dout1), .empty(empty1),
        .almost_empty(ae1), .level(level1), .frame_len(frame_len1), .eof(eof1),
        .overflow(ovf1), .underflow(unf1));

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model of the standard-mode instance.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_dout;
    bit           m_ovf, m_unf, m_eof, m_lock;
    int unsigned  m_len, m_wcnt, m_rcnt;

    task automatic model_step();
        int unsigned flen;
        bit m_full, m_empty, wacc, racc;
        if (srst) begin
            mq.delete();
            m_dout = '0; m_ovf = 0; m_unf = 0; m_eof = 0; m_lock = 0;
            m_len = 0; m_wcnt = 0; m_rcnt = 0;
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_empty = (mq.size() == 0);
            flen    = m_lock ? m_len : frame_len;
            wacc    = wr_en && !m_full && !(flen != 0 && m_wcnt == flen);
            racc    = rd_en && !m_empty;
            if (wr_en && !wacc) m_ovf = 1;
            if (rd_en && m_empty) m_unf = 1;
            if (racc) begin
                m_dout = mq.pop_front();
                m_rcnt++;
            end
            if (wacc) begin
                mq.push_back(din);
                m_wcnt++;
                if (!m_lock) begin
                    m_lock = 1;
                    m_len  = frame_len;
                end
            end
            if (flen != 0 && m_rcnt == flen && mq.size() == 0) m_eof = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("m_level", 64'(level), 64'(mq.size()));
            check("m_empty", 64'(empty), 64'(mq.size() == 0));
            check("m_full",  64'(full),  64'(mq.size() == DEPTH));
            check("m_af",    64'(af),    64'(mq.size() >= 480));
            check("m_ae",    64'(ae),    64'(mq.size() <= 16));
            check("m_dout",  64'(dout),  64'(m_dout));
            check("m_ovf",   64'(ovf),   64'(m_ovf));
            check("m_unf",   64'(unf),   64'(m_unf));
            check("m_eof",   64'(eof),   64'(m_eof));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        srst = 1; wr_en = 0; rd_en = 0; din = '0; frame_len = '0;
        srst1 = 1; wr1 = 0; rd1 = 0; din1 = '0; frame_len1 = '0;
        tick();
        chk_en = 1;
        tick();
        check("rst_level", 64'(level), 0);
        check("rst_empty", 64'(empty), 1);
        check("rst_full",  64'(full), 0);
        check("rst_ae",    64'(ae), 1);
        check("rst_dout",  64'(dout), 0);
        check("rst_eof1",  64'(eof1), 0);
        check("rst_empty1", 64'(empty1), 1);
        srst = 0; srst1 = 0;

        // Four writes then four reads, one-cycle read latency.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; din = 32'h11 + 32'(i);
            tick();
        end
        wr_en = 0;
        check("wr4_level", 64'(level), 4);
        for (int i = 0; i < 4; i++) begin
            rd_en = 1;
            tick();
            rd_en = 0;
            $display("read %0d dout=%0h", i, dout);
            check("rd4_data", 64'(dout), 64'(32'h11 + 32'(i)));
        end
        check("rd4_empty", 64'(empty), 1);

        // Fill to full, then one refused write.
        srst = 1; tick(); srst = 0;
        wr_en = 1;
        for (int i = 0; i < DEPTH; i++) begin
            din = 32'(i);
            tick();
            if (i == 478) check("af_479", 64'(af), 0);
            if (i == 479) check("af_480", 64'(af), 1);
            if (i == 510) check("full_511", 64'(full), 0);
        end
        check("full_512", 64'(full), 1);
        check("level_512", 64'(level), 512);
        din = 32'hDEAD;
        tick();
        wr_en = 0;
        check("ovf_513", 64'(ovf), 1);
        check("level_513", 64'(level), 512);
        $display("fill done level=%0d overflow=%0b", level, ovf);

        // Drain to 100, then 50 cycles of concurrent read/write across the wrap.
        rd_en = 1;
        repeat (412) tick();
        rd_en = 0;
        check("level_100", 64'(level), 100);
        wr_en = 1; rd_en = 1;
        for (int i = 0; i < 50; i++) begin
            din = 32'(1000 + i);
            tick();
        end
        wr_en = 0; rd_en = 0;
        check("level_rw", 64'(level), 100);
        rd_en = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0)  check("wrap_first", 64'(dout), 462);
            if (i == 99) check("wrap_last", 64'(dout), 1049);
        end
        rd_en = 0;
        check("drain_empty", 64'(empty), 1);

        // Read while empty.
        rd_en = 1; tick(); rd_en = 0;
        $display("empty read dout=%0h underflow=%0b", dout, unf);
        check("unf_dout", 64'(dout), 1049);
        check("unf_set", 64'(unf), 1);
        check("unf_level", 64'(level), 0);
        srst = 1; tick(); srst = 0;
        check("unf_clr", 64'(unf), 0);
        check("ovf_clr", 64'(ovf), 0);

        // Frame of 8 words; a later frame_len change must be ignored.
        frame_len = 8;
        wr_en = 1;
        for (int i = 0; i < 10; i++) begin
            din = 32'h100 + 32'(i);
            tick();
            if (i == 2) frame_len = 3;
        end
        wr_en = 0;
        check("frame_level", 64'(level), 8);
        check("frame_ovf", 64'(ovf), 1);
        rd_en = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 6) check("eof_early", 64'(eof), 0);
        end
        rd_en = 0;
        check("eof_set", 64'(eof), 1);
        check("eof_empty", 64'(empty), 1);
        check("eof_dout", 64'(dout), 32'h107);
        repeat (3) tick();
        check("eof_sticky", 64'(eof), 1);
        frame_len = 0;
        srst = 1; tick(); srst = 0;
        check("eof_clr", 64'(eof), 0);

        // First-word-fall-through instance.
        wr1 = 1; din1 = 32'hA5; tick(); wr1 = 0;
        check("fw_empty_c1", 64'(empty1), 1);
        tick();
        check("fw_empty_c2", 64'(empty1), 1);
        tick();
        $display("fwft head dout=%0h empty=%0b", dout1, empty1);
        check("fw_empty_c3", 64'(empty1), 0);
        check("fw_dout", 64'(dout1), 32'hA5);
        check("fw_level", 64'(level1), 1);
        rd1 = 1; tick(); rd1 = 0;
        check("fw_rd_empty", 64'(empty1), 1);
        check("fw_rd_level", 64'(level1), 0);

        srst1 = 1; tick(); srst1 = 0;
        frame_len1 = 2;
        wr1 = 1; din1 = 32'hB1; tick();
        din1 = 32'hB2; tick(); wr1 = 0;
        repeat (3) tick();
        check("fw_b1", 64'(dout1), 32'hB1);
        check("fw_b_level", 64'(level1), 2);
        rd1 = 1; tick();
        check("fw_b2", 64'(dout1), 32'hB2);
        check("fw_b_eof0", 64'(eof1), 0);
        tick(); rd1 = 0;
        check("fw_eof", 64'(eof1), 1);
        check("fw_eof_empty", 64'(empty1), 1);

        srst1 = 1; tick(); srst1 = 0;
        check("fw_eof_clr", 64'(eof1), 0);
        frame_len1 = 4;
        wr1 = 1; din1 = 32'hC1; tick();
        din1 = 32'hC2; tick(); wr1 = 0;
        repeat (3) tick();
        check("fw_mid_full", 64'(empty1), 0);
        srst1 = 1; tick(); srst1 = 0;
        check("fw_mid_empty", 64'(empty1), 1);
        check("fw_mid_level", 64'(level1), 0);
        check("fw_mid_eof", 64'(eof1), 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
